// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results to write-back or runs one data-memory access with ack/timeout.
// Build option MEM_BYTE_ACCESS_EN enables LB/SB byte accesses; without it byte ops raise err.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exValid,
    output logic        exReady,
    input  logic [2:0]  memOp,
    input  logic [31:0] regcData_i,
    input  logic [4:0]  regcAddr_i,
    input  logic        regcWr_i,
    input  logic [31:0] storeData_i,
    output logic        dmReq,
    output logic        dmWe,
    output logic [31:0] dmAddr,
    output logic [31:0] dmWdata,
    output logic [3:0]  dmBe,
    input  logic        dmAck,
    input  logic [31:0] dmRdata,
    output logic [31:0] wbData,
    output logic [4:0]  wbAddr,
    output logic        wbWr,
    output logic        err
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [2:0] OP_LW = 3'b001;
    localparam logic [2:0] OP_SW = 3'b010;
    localparam logic [2:0] OP_LB = 3'b011;
    localparam logic [2:0] OP_SB = 3'b100;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    // Little-endian byte-lane select with sign extension for LB write-back.
    function automatic logic [31:0] load_byte_sext(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        return {{24{b[7]}}, b};
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dm_req_q, dm_req_d;
    logic        dm_we_q, dm_we_d;
    logic [31:0] dm_addr_q, dm_addr_d;
    logic [31:0] dm_wdata_q, dm_wdata_d;
    logic [3:0]  dm_be_q, dm_be_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        wb_wr_q, wb_wr_d;
    logic        err_q, err_d;
    logic [4:0]  rd_addr_q, rd_addr_d;
    logic        rd_wr_q, rd_wr_d;
    logic        byte_q, byte_d;
    logic [1:0]  lane_q, lane_d;

    logic        op_mem_s, op_store_s, op_byte_s, op_legal_s;

    // Operation decode; legality covers word alignment and byte-op availability.
    always_comb begin
        op_mem_s   = 1'b0;
        op_store_s = 1'b0;
        op_byte_s  = 1'b0;
        op_legal_s = 1'b0;
        case (memOp)
            OP_LW: begin
                op_mem_s   = 1'b1;
                op_legal_s = (regcData_i[1:0] == 2'b00);
            end
            OP_SW: begin
                op_mem_s   = 1'b1;
                op_store_s = 1'b1;
                op_legal_s = (regcData_i[1:0] == 2'b00);
            end
            OP_LB: begin
                op_mem_s  = 1'b1;
                op_byte_s = 1'b1;
`ifdef MEM_BYTE_ACCESS_EN
                op_legal_s = 1'b1;
`else
                op_legal_s = 1'b0;
`endif
            end
            OP_SB: begin
                op_mem_s   = 1'b1;
                op_store_s = 1'b1;
                op_byte_s  = 1'b1;
`ifdef MEM_BYTE_ACCESS_EN
                op_legal_s = 1'b1;
`else
                op_legal_s = 1'b0;
`endif
            end
            default: begin
                op_mem_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: acceptance in IDLE, ack/timeout resolution in ACCESS (ack wins).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dm_req_d   = dm_req_q;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_be_d    = dm_be_q;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_wr_d    = 1'b0;
        err_d      = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_wr_d    = rd_wr_q;
        byte_d     = byte_q;
        lane_d     = lane_q;
        case (state_q)
            IDLE: begin
                if (exValid) begin
                    if (!op_mem_s) begin
                        wb_data_d = regcData_i;
                        wb_addr_d = regcAddr_i;
                        wb_wr_d   = regcWr_i;
                    end else if (op_legal_s) begin
                        state_d    = ACCESS;
                        cnt_d      = 8'd0;
                        dm_req_d   = 1'b1;
                        dm_we_d    = op_store_s;
                        dm_addr_d  = {regcData_i[31:2], 2'b00};
                        dm_wdata_d = op_byte_s ? {4{storeData_i[7:0]}} : storeData_i;
                        dm_be_d    = op_byte_s ? (4'b0001 << regcData_i[1:0]) : 4'b1111;
                        rd_addr_d  = regcAddr_i;
                        rd_wr_d    = regcWr_i;
                        byte_d     = op_byte_s;
                        lane_d     = regcData_i[1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (dmAck) begin
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    if (!dm_we_q) begin
                        wb_data_d = byte_q ? load_byte_sext(dmRdata, lane_q) : dmRdata;
                        wb_addr_d = rd_addr_q;
                        wb_wr_d   = rd_wr_q;
                    end else begin
                        wb_wr_d = 1'b0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = IDLE;
                    dm_req_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset also abandons any access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= 32'd0;
            dm_wdata_q <= 32'd0;
            dm_be_q    <= 4'b0000;
            wb_data_q  <= 32'd0;
            wb_addr_q  <= 5'd0;
            wb_wr_q    <= 1'b0;
            err_q      <= 1'b0;
            rd_addr_q  <= 5'd0;
            rd_wr_q    <= 1'b0;
            byte_q     <= 1'b0;
            lane_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dm_req_q   <= dm_req_d;
            dm_we_q    <= dm_we_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_be_q    <= dm_be_d;
            wb_data_q  <= wb_data_d;
            wb_addr_q  <= wb_addr_d;
            wb_wr_q    <= wb_wr_d;
            err_q      <= err_d;
            rd_addr_q  <= rd_addr_d;
            rd_wr_q    <= rd_wr_d;
            byte_q     <= byte_d;
            lane_q     <= lane_d;
        end
    end

    assign exReady = (state_q == IDLE);
    assign dmReq   = dm_req_q;
    assign dmWe    = dm_we_q;
    assign dmAddr  = dm_addr_q;
    assign dmWdata = dm_wdata_q;
    assign dmBe    = dm_be_q;
    assign wbData  = wb_data_q;
    assign wbAddr  = wb_addr_q;
    assign wbWr    = wb_wr_q;
    assign err     = err_q;

endmodule
